// File: rtl/nios_pio_out_pulse.sv
// nios_pio_out_pulse
//   Avalon-MM slave output PIO. The CPU writes a DATA register that drives
//   out_port_o, and can set or clear individual bits atomically through the
//   OUTSET/OUTCLEAR strobes. An optional pulse engine drives selected bits
//   high for a programmed number of clocks and then releases them.
//
//   Optional feature macro: NIOS_PIO_OUT_PULSE_EN
//     defined   -> pulse engine plus PULSE_WIDTH/PULSE/STATUS registers
//     undefined -> addresses 1..3 read 0 and ignore writes
//
//   Register map (word address):
//     0 DATA (RW)   1 PULSE_WIDTH (RW)   2 PULSE (W: trigger, R: active mask)
//     3 STATUS (RO, bit0 busy)   4 OUTSET (WO)   5 OUTCLEAR (WO)   6,7 reserved
//
//   Bus handshake: a write happens on any rising edge where chipselect_i=1
//   and write_n_i=0. There is no wait state; readdata_o is re-registered
//   every clock from the current address_i, so a master samples it one cycle
//   after presenting the read address.
//
// Ports:
//   clk_i         system clock
//   reset_i       synchronous, active-high reset
//   chipselect_i  slave select
//   write_n_i     active-low write strobe
//   address_i     word address (3 bits)
//   writedata_i   write data; bits above the register width are ignored
//   readdata_o    registered read data, zero-extended
//   out_port_o    registered output pins = DATA | active pulse mask
module nios_pio_out_pulse #(
    parameter int          WIDTH       = 4,
    parameter int          PW_BITS     = 16,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             chipselect_i,
    input  logic             write_n_i,
    input  logic [2:0]       address_i,
    input  logic [31:0]      writedata_i,
    output logic [31:0]      readdata_o,
    output logic [WIDTH-1:0] out_port_o
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_PW       = 3'd1;
    localparam logic [2:0] ADDR_PULSE    = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    logic             wr_en;
    logic [WIDTH-1:0] wdata_w;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [31:0]      readdata_q, readdata_d;

    // Upper writedata bits are deliberately ignored.
    logic unused_wdata;
    assign unused_wdata = ^writedata_i;

    assign wr_en   = chipselect_i & ~write_n_i;
    assign wdata_w = writedata_i[WIDTH-1:0];

    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (address_i)
                ADDR_DATA:     data_d = wdata_w;
                ADDR_OUTSET:   data_d = data_q | wdata_w;
                ADDR_OUTCLEAR: data_d = data_q & ~wdata_w;
                default:       data_d = data_q;
            endcase
        end
    end

`ifdef NIOS_PIO_OUT_PULSE_EN
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [PW_BITS-1:0] pw_q, pw_d;
    logic [PW_BITS-1:0] count_q, count_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic               trigger;

    // A zero mask is not a trigger: it must not restart the counter.
    assign trigger = wr_en && (address_i == ADDR_PULSE) && (wdata_w != '0);

    always_comb begin
        pw_d    = pw_q;
        mask_d  = mask_q;
        count_d = count_q;
        state_d = state_q;
        if (wr_en && (address_i == ADDR_PW)) begin
            pw_d = writedata_i[PW_BITS-1:0];
        end
        if (trigger) begin
            // Retrigger in ACTIVE reloads the count, stretching every bit
            // already in the mask. A width of 0 is treated as 1.
            mask_d  = mask_q | wdata_w;
            count_d = (pw_q == '0) ? PW_BITS'(1) : pw_q;
            state_d = ST_ACTIVE;
        end else if (state_q == ST_ACTIVE) begin
            count_d = count_q - PW_BITS'(1);
            if (count_q == PW_BITS'(1)) begin
                mask_d  = '0;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pw_q    <= '0;
            mask_q  <= '0;
            count_q <= '0;
            state_q <= ST_IDLE;
        end else begin
            pw_q    <= pw_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    assign out_d = data_q | mask_q;

    always_comb begin
        readdata_d = '0;
        case (address_i)
            ADDR_DATA:   readdata_d = 32'(data_q);
            ADDR_PW:     readdata_d = 32'(pw_q);
            ADDR_PULSE:  readdata_d = 32'(mask_q);
            ADDR_STATUS: readdata_d = {31'b0, (state_q == ST_ACTIVE)};
            default:     readdata_d = '0;
        endcase
    end
`else
    assign out_d = data_q;

    always_comb begin
        readdata_d = '0;
        if (address_i == ADDR_DATA) begin
            readdata_d = 32'(data_q);
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q     <= RESET_VALUE[WIDTH-1:0];
            out_q      <= RESET_VALUE[WIDTH-1:0];
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            out_q      <= out_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata_o = readdata_q;
    assign out_port_o = out_q;

endmodule

// File: tb/tb_nios_pio_out_pulse.sv
// Testbench for nios_pio_out_pulse (WIDTH=4, PW_BITS=16, RESET_VALUE=4'h5).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after the rising edge that consumed them.
module tb_nios_pio_out_pulse;

    logic        clk;
    logic        reset;
    logic        chipselect;
    logic        write_n;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  out_port;

    int n_vec;
    int n_fail;

    nios_pio_out_pulse #(
        .WIDTH      (4),
        .PW_BITS    (16),
        .RESET_VALUE(32'h5)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .chipselect_i(chipselect),
        .write_n_i   (write_n),
        .address_i   (address),
        .writedata_i (writedata),
        .readdata_o  (readdata),
        .out_port_o  (out_port)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector record ----------------
    typedef struct {
        logic        cs;
        logic        wn;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  exp_out;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[21];

    // ---------------- driver tasks ----------------
    // Called at a falling edge: present inputs, let one rising edge consume
    // them, return at the next falling edge ready to sample.
    task automatic step(input logic cs, input logic wn, input logic [2:0] addr,
                        input logic [31:0] wdata);
        chipselect = cs;
        write_n    = wn;
        address    = addr;
        writedata  = wdata;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] wdata);
        step(1'b1, 1'b0, addr, wdata);
    endtask

    task automatic rd(input logic [2:0] addr);
        step(1'b1, 1'b1, addr, 32'h0);
    endtask

    task automatic check_out(input string name, input logic [3:0] exp);
        n_vec++;
        if (out_port !== exp) begin
            n_fail++;
            $display("FAIL %s: out_port=%h expected %h", name, out_port, exp);
        end
    endtask

    task automatic check_rd(input string name, input logic [31:0] exp);
        n_vec++;
        if (readdata !== exp) begin
            n_fail++;
            $display("FAIL %s: readdata=%h expected %h", name, readdata, exp);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        n_vec = 0;
        n_fail = 0;

        // Expected values are after the edge that consumed the vector:
        // out_port lags DATA by one edge, readdata shows pre-edge state.
        vecs[0]  = '{1'b1, 1'b1, 3'd0, 32'h0,        4'h5, 32'h5};
        vecs[1]  = '{1'b1, 1'b0, 3'd0, 32'hA,        4'h5, 32'h5};
        vecs[2]  = '{1'b1, 1'b0, 3'd4, 32'h1,        4'hA, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 3'd5, 32'h8,        4'hB, 32'h0};
        vecs[4]  = '{1'b1, 1'b1, 3'd0, 32'h0,        4'h3, 32'h3};
        vecs[5]  = '{1'b1, 1'b0, 3'd0, 32'h12345670, 4'h3, 32'h3};
        vecs[6]  = '{1'b1, 1'b1, 3'd0, 32'h0,        4'h0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 3'd6, 32'hF,        4'h0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 3'd7, 32'hF,        4'h0, 32'h0};
        vecs[9]  = '{1'b1, 1'b1, 3'd6, 32'h0,        4'h0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 3'd0, 32'h9,        4'h0, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 3'd4, 32'h0,        4'h9, 32'h0};
        vecs[12] = '{1'b1, 1'b1, 3'd5, 32'h0,        4'h9, 32'h0};
        vecs[13] = '{1'b0, 1'b0, 3'd0, 32'h6,        4'h9, 32'h9};
        vecs[14] = '{1'b1, 1'b1, 3'd0, 32'h6,        4'h9, 32'h9};
        vecs[15] = '{1'b1, 1'b1, 3'd0, 32'h0,        4'h9, 32'h9};
        vecs[16] = '{1'b1, 1'b0, 3'd4, 32'h6,        4'h9, 32'h0};
        vecs[17] = '{1'b1, 1'b0, 3'd5, 32'h3,        4'hF, 32'h0};
        vecs[18] = '{1'b1, 1'b1, 3'd0, 32'h0,        4'hC, 32'hC};
        vecs[19] = '{1'b1, 1'b0, 3'd0, 32'h9,        4'hC, 32'hC};
        vecs[20] = '{1'b1, 1'b1, 3'd0, 32'h0,        4'h9, 32'h9};

        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_out("reset_out", 4'h5);
        check_rd("reset_rd", 32'h0);

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wdata);
            check_out($sformatf("vec%0d_out", i), vecs[i].exp_out);
            check_rd($sformatf("vec%0d_rd", i), vecs[i].exp_rd);
        end
        // DATA is 4'h9 here.

`ifdef NIOS_PIO_OUT_PULSE_EN
        // Single pulse, width 3, on a zero DATA background.
        wr(3'd1, 32'd3);
        wr(3'd0, 32'h0);
        wr(3'd2, 32'h2);
        check_out("p1_trig_edge", 4'h0);
        for (int j = 1; j <= 5; j++) begin
            rd(3'd3);
            check_out($sformatf("p1_out_k%0d", j), (j <= 3) ? 4'h2 : 4'h0);
            check_rd($sformatf("p1_busy_k%0d", j), (j <= 3) ? 32'h1 : 32'h0);
        end

        // Retrigger: width 5, bit0 at edge k, bit2 at edge k+2.
        wr(3'd1, 32'd5);
        wr(3'd2, 32'h1);
        check_out("p2_k0", 4'h0);
        rd(3'd2);
        check_out("p2_k1", 4'h1);
        check_rd("p2_mask_k1", 32'h1);
        wr(3'd2, 32'h4);
        check_out("p2_k2", 4'h1);
        for (int j = 3; j <= 9; j++) begin
            rd(3'd2);
            check_out($sformatf("p2_out_k%0d", j), (j <= 7) ? 4'h5 : 4'h0);
            check_rd($sformatf("p2_mask_k%0d", j), (j <= 7) ? 32'h5 : 32'h0);
        end

        // Reset in the middle of a width-10 pulse.
        wr(3'd1, 32'd10);
        wr(3'd2, 32'hF);
        for (int j = 1; j <= 4; j++) begin
            rd(3'd0);
            check_out($sformatf("p3_out_k%0d", j), 4'hF);
        end
        reset = 1'b1;
        rd(3'd0);
        reset = 1'b0;
        check_out("p3_reset_out", 4'h5);
        check_rd("p3_reset_rd", 32'h0);
        rd(3'd3);
        check_rd("p3_status", 32'h0);
        check_out("p3_out_after", 4'h5);
        rd(3'd2);
        check_rd("p3_mask", 32'h0);
        rd(3'd1);
        check_rd("p3_pw", 32'h0);

        // Width 0 behaves as 1; DATA=5 stays underneath.
        wr(3'd2, 32'h8);
        check_out("p4_k0", 4'h5);
        rd(3'd3);
        check_out("p4_k1", 4'hD);
        check_rd("p4_busy_k1", 32'h1);
        rd(3'd3);
        check_out("p4_k2", 4'h5);
        check_rd("p4_busy_k2", 32'h0);

        // Zero trigger mask does nothing.
        wr(3'd2, 32'h0);
        rd(3'd3);
        check_rd("p5_busy", 32'h0);
        check_out("p5_out", 4'h5);
`else
        // Pulse registers absent: writes to 1..3 ignored, reads return 0.
        wr(3'd1, 32'h3);
        wr(3'd2, 32'hF);
        check_out("nopulse_w2", 4'h9);
        rd(3'd1);
        check_out("nopulse_out", 4'h9);
        rd(3'd1);
        check_rd("nopulse_rd1", 32'h0);
        rd(3'd2);
        check_rd("nopulse_rd2", 32'h0);
        rd(3'd3);
        check_rd("nopulse_rd3", 32'h0);
        check_out("nopulse_out2", 4'h9);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
